// File: rtl/dm_pkg.sv
// Shared types and helpers for the wait-state data memory (dm_wait_ctrl).
// Contents: size encodings, FSM state enum, registered request payload,
// and the access misalignment check.
package dm_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, EXEC} dm_state_e;

  typedef struct packed {
    logic            we;
    logic [1:0]      size;
    logic            sgn;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dm_req_t;

  // Half must be even, word must be 4-aligned, reserved size always faults.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_wait_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// req_*: valid/ready request with store data and issuing PC.
// rsp_*: one-cycle completion pulse with load data and error flag.
// init_done: post-reset clear sweep has finished.
interface dm_wait_ctrl_if;
  import dm_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] req_pc;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic            init_done;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane unit (little-endian, lane 0 = bits [7:0]).
// LOAD_MODE=0: result is old_word with wdata merged into the addressed lane(s).
// LOAD_MODE=1: result is the addressed lane(s) of old_word, zero/sign-extended.
// Ports: old_word_i, off_i (byte offset), size_i, sgn_i, wdata_i -> result_c_o.
module dm_lane_unit
  import dm_pkg::*;
#(
  parameter bit LOAD_MODE = 1'b0
) (
  input  logic [XLEN-1:0] old_word_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] result_c_o
);

  logic [XLEN-1:0] merged_c;
  logic [XLEN-1:0] loaded_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;

  // Store merge: only the addressed lanes take new data.
  always_comb begin
    merged_c = old_word_i;
    case (size_i)
      SZ_BYTE: merged_c[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_c[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_c = wdata_i;
    endcase
  end

  // Load extract and extend; a word ignores the signed flag.
  always_comb begin
    byte_c = old_word_i[{off_i, 3'b000} +: 8];
    half_c = old_word_i[{off_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: loaded_c = {{24{sgn_i & byte_c[7]}}, byte_c};
      SZ_HALF: loaded_c = {{16{sgn_i & half_c[15]}}, half_c};
      default: loaded_c = old_word_i;
    endcase
  end

  assign result_c_o = LOAD_MODE ? loaded_c : merged_c;

endmodule

// File: rtl/dm_wait_ctrl.sv
// Word-organised data memory behind a valid/ready port with configurable wait
// states, sub-word store merge, extended sub-word loads and an error flag.
// After reset a sweep writes zero to every word before requests are accepted.
// Ports: clk, reset (async, active-low), bus (dm_wait_ctrl_if.slave).
// Optional: define DM_TRACE_EN to print each committed store.
module dm_wait_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset,
  dm_wait_ctrl_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  dm_state_e       state_q, state_d;
  logic [AW-1:0]   init_idx_q, init_idx_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  dm_req_t         req_q, req_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            init_done_q, init_done_d;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [XLEN-1:0] mem_wdata_c;

  logic [XLEN-1:0] offset_c;
  logic [AW-1:0]   idx_c;
  logic            err_c;
  logic [XLEN-1:0] rd_word_c;
  logic [XLEN-1:0] merged_c;
  logic [XLEN-1:0] loaded_c;

  // Address decode of the registered request; BASE_ADDR is DEPTH*4 aligned.
  assign offset_c  = req_q.addr - BASE_ADDR;
  assign idx_c     = offset_c[AW+1:2];
  assign err_c     = (req_q.addr < BASE_ADDR) || (offset_c[XLEN-1:AW+2] != '0) ||
                     misaligned(req_q.size, offset_c[1:0]);
  assign rd_word_c = mem_q[idx_c];

  dm_lane_unit #(.LOAD_MODE(1'b0)) u_merge (
    .old_word_i (rd_word_c),
    .off_i      (offset_c[1:0]),
    .size_i     (req_q.size),
    .sgn_i      (req_q.sgn),
    .wdata_i    (req_q.wdata),
    .result_c_o (merged_c)
  );

  dm_lane_unit #(.LOAD_MODE(1'b1)) u_load (
    .old_word_i (rd_word_c),
    .off_i      (offset_c[1:0]),
    .size_i     (req_q.size),
    .sgn_i      (req_q.sgn),
    .wdata_i    (req_q.wdata),
    .result_c_o (loaded_c)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      wait_cnt_q  <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  // RAM array; writes come only from the sweep or a committing EXEC.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    wait_cnt_d  = wait_cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    init_done_d = init_done_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = idx_c;
    mem_wdata_c = merged_c;

    case (state_q)
      INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_idx_q;
        mem_wdata_c = '0;
        if (init_idx_q == AW'(DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + AW'(1);
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          req_d.we    = bus.req_we;
          req_d.size  = bus.req_size;
          req_d.sgn   = bus.req_signed;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          wait_cnt_d  = CW'(WAIT_CYCLES);
          state_d     = (WAIT_CYCLES > 0) ? WAIT : EXEC;
        end
      end
      WAIT: begin
        if (wait_cnt_q <= CW'(1)) state_d = EXEC;
        else                      wait_cnt_d = wait_cnt_q - CW'(1);
      end
      EXEC: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        if (err_c) begin
          rsp_err_d = 1'b1;
        end else if (req_q.we) begin
          mem_we_c = 1'b1;
        end else begin
          rsp_rdata_d = loaded_c;
        end
      end
      default: state_d = INIT;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = init_done_q;

`ifdef DM_TRACE_EN
  logic [XLEN-1:0] pc_q;

  // PC of the accepted request, kept for the store trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                pc_q <= '0;
    else if (state_q == IDLE && bus.req_valid) pc_q <= bus.req_pc;
  end

  // Trace each committed legal store with its full post-merge word.
  always_ff @(posedge clk) begin
    if (state_q == EXEC && !err_c && req_q.we)
      $display("%0t@%h: *%h <= %h", $time, pc_q, {req_q.addr[XLEN-1:2], 2'b00}, merged_c);
  end
`endif

endmodule

// File: tb/tb_dm_wait_ctrl.sv
// Directed bench for dm_wait_ctrl: u0 (DEPTH 16, no wait states) and
// u3 (DEPTH 32, three wait states) share the clock and a request driver.
module tb_dm_wait_ctrl;
  import dm_pkg::*;

  logic clk;
  logic rst0_n, rst3_n;
  logic sel;
  logic r_valid, r_we, r_sgn;
  logic [1:0] r_size;
  logic [31:0] r_addr, r_wdata, r_pc;
  int tests, fails;
  logic [31:0] mem0 [16];

  dm_wait_ctrl_if b0 ();
  dm_wait_ctrl_if b3 ();

  dm_wait_ctrl #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst0_n), .bus(b0));
  dm_wait_ctrl #(.DEPTH(32), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(rst3_n), .bus(b3));

  assign b0.req_valid  = r_valid & ~sel;
  assign b3.req_valid  = r_valid & sel;
  assign b0.req_we     = r_we;     assign b3.req_we     = r_we;
  assign b0.req_size   = r_size;   assign b3.req_size   = r_size;
  assign b0.req_signed = r_sgn;    assign b3.req_signed = r_sgn;
  assign b0.req_addr   = r_addr;   assign b3.req_addr   = r_addr;
  assign b0.req_wdata  = r_wdata;  assign b3.req_wdata  = r_wdata;
  assign b0.req_pc     = r_pc;     assign b3.req_pc     = r_pc;

  wire        ready_m = sel ? b3.req_ready : b0.req_ready;
  wire        rvld_m  = sel ? b3.rsp_valid : b0.rsp_valid;
  wire [31:0] rdata_m = sel ? b3.rsp_rdata : b0.rsp_rdata;
  wire        rerr_m  = sel ? b3.rsp_err   : b0.rsp_err;
  wire        idone_m = sel ? b3.init_done : b0.init_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request on the selected DUT and wait for its response pulse.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int rdy_low);
    int n;
    bit got;
    rd = '0; er = 1'b0; lat = 0; rdy_low = 0; n = 0; got = 0;
    @(negedge clk);
    while (!ready_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_m) begin
      fails++;
      $display("FAIL xact_ready_timeout addr=%h", a);
      return;
    end
    r_valid = 1'b1; r_we = we; r_size = sz; r_sgn = sg; r_addr = a; r_wdata = wd;
    r_pc = 32'h0000_1000 + a;
    @(posedge clk);
    #1 r_valid = 1'b0;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (!ready_m) rdy_low++;
      if (rvld_m) begin
        got = 1;
        rd = rdata_m;
        er = rerr_m;
      end
    end
    if (!got) begin
      fails++;
      $display("FAIL xact_rsp_timeout addr=%h", a);
    end
  endtask

  task automatic test_reset(input logic s, input int depth);
    sel = s;
    repeat (2) @(negedge clk);
    tests++;
    if ({ready_m, rvld_m, rdata_m, rerr_m, idone_m} !== 36'h0) begin
      fails++;
      $display("FAIL reset_outputs dut=%0d got rdy=%b vld=%b rd=%h err=%b done=%b want all 0",
               s, ready_m, rvld_m, rdata_m, rerr_m, idone_m);
    end
    if (s) rst3_n = 1'b1; else rst0_n = 1'b1;
    for (int c = 1; c <= depth; c++) begin
      @(negedge clk);
      tests++;
      if (idone_m !== (c == depth) || ready_m !== (c == depth)) begin
        fails++;
        $display("FAIL init_sweep dut=%0d cycle=%0d got done=%b rdy=%b want %b",
                 s, c, idone_m, ready_m, (c == depth));
      end
    end
  endtask

  task automatic test_load_after_init();
    logic [31:0] rd; logic er; int lat, rl;
    sel = 1'b0;
    xact(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat, rl);
    tests++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2 || rl !== 1) begin
      fails++;
      $display("FAIL load_after_init got rd=%h err=%b lat=%0d rlow=%0d want 0 0 2 1", rd, er, lat, rl);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat, rl;
    logic [31:0] exp_rd [10];
    logic        v_we  [10];
    logic [1:0]  v_sz  [10];
    logic        v_sg  [10];
    logic [31:0] v_a   [10];
    logic [31:0] v_wd  [10];
    sel = 1'b0;
    v_we = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    v_sz = '{SZ_WORD, SZ_BYTE, SZ_BYTE, SZ_WORD, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF, SZ_HALF};
    v_sg = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 1};
    v_a  = '{32'h20, 32'h21, 32'h23, 32'h20, 32'h23, 32'h23, 32'h22, 32'h22, 32'h20, 32'h20};
    v_wd = '{32'h12345678, 32'h0, 32'hAAAAAAF0, 32'h0, 32'h0, 32'h0, 32'h5555ABCD, 32'h0, 32'h0, 32'h0};
    exp_rd = '{32'h0, 32'h00000056, 32'h0, 32'hF0345678, 32'hFFFFFFF0, 32'h000000F0,
               32'h0, 32'hFFFFABCD, 32'h00005678, 32'h00005678};
    for (int i = 0; i < 10; i++) begin
      xact(v_we[i], v_sz[i], v_sg[i], v_a[i], v_wd[i], rd, er, lat, rl);
      tests++;
      if (rd !== exp_rd[i] || er !== 1'b0) begin
        fails++;
        $display("FAIL store_load step=%0d got rd=%h err=%b want rd=%h err=0", i, rd, er, exp_rd[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        tests++;
        if (rvld_m !== 1'b0 || rdata_m !== 32'h0) begin
          fails++;
          $display("FAIL rsp_pulse_width got vld=%b rd=%h want 0 0", rvld_m, rdata_m);
        end
      end
    end
    mem0[8] = 32'hABCD5678;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, rl;
    logic        v_we [4];
    logic [1:0]  v_sz [4];
    logic [31:0] v_a  [4];
    sel = 1'b0;
    v_we = '{0, 1, 0, 1};
    v_sz = '{SZ_HALF, SZ_WORD, SZ_RSVD, SZ_RSVD};
    v_a  = '{32'h21, 32'h22, 32'h20, 32'h20};
    for (int i = 0; i < 4; i++) begin
      xact(v_we[i], v_sz[i], 1'b1, v_a[i], 32'h99999999, rd, er, lat, rl);
      tests++;
      if (rd !== 32'h0 || er !== 1'b1) begin
        fails++;
        $display("FAIL error_case=%0d got rd=%h err=%b want rd=0 err=1", i, rd, er);
      end
    end
    xact(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat, rl);
    tests++;
    if (rd !== mem0[8] || er !== 1'b0) begin
      fails++;
      $display("FAIL error_no_write got rd=%h err=%b want rd=%h err=0", rd, er, mem0[8]);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat, rl;
    sel = 1'b0;
    xact(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hDEADBEEF, rd, er, lat, rl);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL range_store got rd=%h err=%b want rd=0 err=1", rd, er);
    end
    xact(1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0, rd, er, lat, rl);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL range_load got rd=%h err=%b want rd=0 err=1", rd, er);
    end
    for (int i = 0; i < 16; i++) begin
      xact(1'b0, SZ_WORD, 1'b0, 32'(i * 4), 32'h0, rd, er, lat, rl);
      tests++;
      if (rd !== mem0[i] || er !== 1'b0) begin
        fails++;
        $display("FAIL ram_compare word=%0d got rd=%h err=%b want %h", i, rd, er, mem0[i]);
      end
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd; logic er; int lat, rl;
    sel = 1'b1;
    xact(1'b1, SZ_WORD, 1'b0, 32'h8, 32'h11223344, rd, er, lat, rl);
    tests++;
    if (lat !== 5 || rl !== 4 || er !== 1'b0 || rd !== 32'h0) begin
      fails++;
      $display("FAIL wait_store got lat=%0d rlow=%0d err=%b rd=%h want 5 4 0 0", lat, rl, er, rd);
    end
    xact(1'b0, SZ_HALF, 1'b1, 32'hA, 32'h0, rd, er, lat, rl);
    tests++;
    if (lat !== 5 || rl !== 4 || er !== 1'b0 || rd !== 32'h00001122) begin
      fails++;
      $display("FAIL wait_load got lat=%0d rlow=%0d err=%b rd=%h want 5 4 0 00001122", lat, rl, er, rd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat, rl, c;
    bit stray;
    sel = 1'b1;
    @(negedge clk);
    r_valid = 1'b1; r_we = 1'b1; r_size = SZ_WORD; r_sgn = 1'b0;
    r_addr = 32'h40; r_wdata = 32'hCAFEBABE; r_pc = 32'h0000_2040;
    @(posedge clk);
    #1 r_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst3_n = 1'b0;
    #1;
    tests++;
    if ({ready_m, rvld_m, rerr_m, idone_m} !== 4'b0) begin
      fails++;
      $display("FAIL reset_in_wait_outputs got rdy=%b vld=%b err=%b done=%b want 0",
               ready_m, rvld_m, rerr_m, idone_m);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    c = 0; stray = 0;
    while (!idone_m && c < 100) begin
      @(negedge clk);
      c++;
      if (rvld_m) stray = 1;
    end
    tests++;
    if (c !== 32 || stray) begin
      fails++;
      $display("FAIL resweep got cycles=%0d stray_rsp=%b want 32 0", c, stray);
    end
    xact(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, rd, er, lat, rl);
    tests++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      fails++;
      $display("FAIL store_lost got rd=%h err=%b want 0 0", rd, er);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst0_n = 1'b0; rst3_n = 1'b0; sel = 1'b0;
    r_valid = 1'b0; r_we = 1'b0; r_size = SZ_WORD; r_sgn = 1'b0;
    r_addr = '0; r_wdata = '0; r_pc = '0;
    for (int i = 0; i < 16; i++) mem0[i] = 32'h0;

    test_reset(1'b0, 16);
    test_load_after_init();
    test_store_load();
    test_errors();
    test_range();
    test_reset(1'b1, 32);
    test_wait();
    test_reset_in_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_wait_ctrl.md
Name: dm_wait_ctrl

Overview:
- Parametrised successor of the single-cycle data memory: word-organised RAM behind a valid/ready request port with a one-cycle response pulse.
- Adds byte/halfword/word stores with lane merge, sign/zero-extended sub-word loads, configurable wait states and a misalignment/range error flag.
- Replaces the blocking reset clear with a sequential post-reset clear sweep.
- Sits in the MEM stage; the pipeline stalls while a request is outstanding.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- WAIT_CYCLES, 0, extra cycles between acceptance and response, 0..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: sign-extend sub-word data.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the issuing instruction; used by the trace only.
- rsp_valid  out  1  one-cycle pulse; the request has completed.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, out of range, or size 11.
- init_done  out  1  clear sweep finished.

Behaviour:
- Reset (async, low): FSM enters INIT, sweep index 0, and outputs go to req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. An in-flight request is aborted and its pending store is discarded.
- INIT: writes 0 to word[idx] each cycle, idx increments; after word DEPTH-1, go to IDLE and set init_done=1. The sweep takes DEPTH cycles after reset deasserts.
- Requests arriving during INIT are not accepted; the requester holds them.
- IDLE: req_ready=1. Handshake at edge T when req_valid & req_ready. All request fields are registered, then go to WAIT if WAIT_CYCLES>0, else EXEC.
- WAIT: counter runs from WAIT_CYCLES down to 1, one decrement per cycle, then go to EXEC. req_ready=0.
- EXEC: one cycle. At its closing edge, a legal store is written and a load's data is captured. rsp_valid=1 for the following cycle, FSM returns to IDLE (req_ready=1 in that same cycle).
- Latency: rsp_valid is high in the cycle after edge T+1+WAIT_CYCLES. Throughput is one request per 2+WAIT_CYCLES cycles.
- Error: word index = (addr-BASE_ADDR)>>2. Error if that index is >= DEPTH or addr < BASE_ADDR. Error if half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - On error: no write; rsp_rdata=0; rsp_err=1.
- Store merge: a byte store replaces lane addr[1:0]; a half store replaces lanes {addr[1],0} and {addr[1],1}; other lanes are preserved. Little-endian: lane 0 is bits [7:0].
- Load: selects the lane(s), then zero-extends or sign-extends per req_signed; a word ignores req_signed.
- rsp_valid, rsp_rdata and rsp_err are registered and return to 0 the cycle after the pulse.
- No response backpressure: the consumer must take the pulse.

Optional Feature:
- DM_TRACE_EN defined: each committed legal store prints "$time@pc: *byteaddr <= mergedword" via $display at the commit edge. byteaddr is the word-aligned address; mergedword is the full 32-bit post-merge word. INIT writes are not printed.
- DM_TRACE_EN undefined: no display code is compiled; the RTL is otherwise identical.

Decomposition:
- Package dm_pkg:
  - size encoding constants SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state enum INIT/IDLE/WAIT/EXEC;
  - a function that computes the misalignment check.
- Sub-module dm_lane_unit: purely combinational store-merge and load-extract/extend, taking the old word, offset, size, signed flag and wdata. Used twice: merge path and load path.

Test Plan:
- Reset then wait: init_done rises exactly DEPTH cycles after reset deasserts; req_ready stays 0 until then. A load of addr 0x10 then returns 0.
- Store word 0x12345678 at 0x20, then load byte signed at 0x21 -> 0x00000056. Store byte 0xF0 at 0x23, then load word 0x20 -> 0xF0345678. Load byte signed at 0x23 -> 0xFFFFFFF0; load byte unsigned -> 0x000000F0.
- WAIT_CYCLES=3: request accepted at edge T gives rsp_valid high exactly in the cycle after edge T+4; req_ready stays low for 4 cycles.
- Misaligned half load at 0x21, misaligned word store at 0x22, and size 11 -> rsp_err=1, rdata=0; the word at 0x20 is unchanged.
- Out of range store at BASE_ADDR+DEPTH*4 -> rsp_err=1; no RAM word changes (full compare against the model).
- Reset asserted during WAIT of a store at 0x40 -> the store is lost, the sweep restarts, and the word at 0x40 reads 0 after init_done.
